// File: rtl/pump_plc_pkg.sv
// Shared types and helpers for the N-pump tank-fill controller.
// Latency: none (declarations and a combinational helper only).
// Backpressure: not applicable.
package pump_plc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_FILL_LEAD = 2'd1,
        ST_FILL_ALL  = 2'd2,
        ST_LOCKOUT   = 2'd3
    } plc_state_e;

    localparam int MAX_PUMPS = 8;

    // Next index after cur whose healthy bit is set, wrapping at n_pumps.
    // cur itself is the last candidate; with no healthy pump, cur is returned.
    function automatic logic [2:0] next_healthy(
        input logic [2:0] cur,
        input logic [7:0] healthy,
        input int         n_pumps
    );
        logic [2:0] res;
        logic       found;
        logic [3:0] idx;
        res   = cur;
        found = 1'b0;
        for (int k = 1; k <= MAX_PUMPS; k++) begin
            idx = {1'b0, cur} + 4'(k);
            if (idx >= 4'(n_pumps)) begin
                idx = idx - 4'(n_pumps);
            end
            if (!found && (k <= n_pumps) && healthy[idx[2:0]]) begin
                res   = idx[2:0];
                found = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/pump_tick_gen.sv
// Control-tick strobe: one-clock pulse every TICK_DIV clocks.
// Latency: first pulse TICK_DIV-1 clocks after reset release, then periodic.
// Backpressure: none; free-running.
module pump_tick_gen #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic tick_o
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Wrap the divider at the last count.
    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end

    // Divider counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/multi_pump_plc.sv
// N-pump tank-fill controller: hysteresis FSM, lead rotation, dwell, stall lockout, level display.
// Latency: pumps/state update on the edge after the deciding tick; trips and flags in one clock.
// Backpressure: none; level is sampled every clock, pump_fault is level-sensitive.
module multi_pump_plc
    import pump_plc_pkg::*;
#(
    parameter int N_PUMPS       = 2,
    parameter int LVL_W         = 8,
    parameter int IND_SEGS      = 8,
    parameter int LOW_TH        = 64,
    parameter int MID_TH        = 128,
    parameter int HIGH_TH       = 224,
    parameter int TICK_DIV      = 100_000_000,
    parameter int MIN_ON_TICKS  = 4,
    parameter int MIN_OFF_TICKS = 4,
    parameter int STALL_TICKS   = 16
) (
    input  logic                CLK100MHZ,
    input  logic                rst_n,
    input  logic [LVL_W-1:0]    water_lvl,
    input  logic [N_PUMPS-1:0]  pump_fault,
    input  logic                fault_clr,
    output logic [N_PUMPS-1:0]  pump_on,
    output logic                Low,
    output logic                Mid,
    output logic                High,
    output logic [IND_SEGS-1:0] water_indication,
    output logic                water_trend,
    output logic                alarm,
    output logic [1:0]          state
);

    localparam int SEG_SHIFT = LVL_W - $clog2(IND_SEGS);
    localparam int DWELL_MAX = (MIN_ON_TICKS > MIN_OFF_TICKS) ? MIN_ON_TICKS : MIN_OFF_TICKS;
    localparam int DW_W      = (DWELL_MAX > 0) ? $clog2(DWELL_MAX + 1) : 1;
    localparam int ST_W      = $clog2(STALL_TICKS + 1);
    localparam logic [7:0] VALID_MASK = 8'((32'd1 << N_PUMPS) - 32'd1);

    logic tick;

    pump_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk_i  (CLK100MHZ),
        .rst_ni (rst_n),
        .tick_o (tick)
    );

    plc_state_e          state_q, state_d;
    logic [2:0]          lead_q, lead_d, lead_t;
    logic [7:0]          lock_q, lock_d;
    logic [DW_W-1:0]     on_dw_q, on_dw_d, off_dw_q, off_dw_d, on_inc, off_inc;
    logic [ST_W-1:0]     stall_q, stall_d;
    logic [LVL_W-1:0]    prev_q, prev_d, q_lvl;
    logic                trend_q, trend_d;
    logic [N_PUMPS-1:0]  pump_q, pump_d;
    logic                alarm_q, alarm_d;
    logic                low_q, mid_q, high_q;
    logic [IND_SEGS-1:0] ind_q, ind_d;
    logic [7:0]          fault8, healthy, healthy_n, pump8;
    logic                lvl_low, lvl_mid, lvl_high, rising, falling, stall_hit, rotate;

    // Control decisions: trips every clock, FSM/dwell/stall/trend on tick, lockout handling.
    always_comb begin
        fault8   = 8'(pump_fault) & VALID_MASK;
        healthy  = ~fault8 & ~lock_q & VALID_MASK;
        lvl_low  = water_lvl <  LVL_W'(LOW_TH);
        lvl_mid  = water_lvl >= LVL_W'(MID_TH);
        lvl_high = water_lvl >= LVL_W'(HIGH_TH);
        rising   = water_lvl > prev_q;
        falling  = water_lvl < prev_q;
        on_inc   = (on_dw_q  == DW_W'(DWELL_MAX)) ? on_dw_q  : on_dw_q  + DW_W'(1);
        off_inc  = (off_dw_q == DW_W'(DWELL_MAX)) ? off_dw_q : off_dw_q + DW_W'(1);

        state_d   = state_q;
        lock_d    = lock_q;
        on_dw_d   = on_dw_q;
        off_dw_d  = off_dw_q;
        stall_d   = stall_q;
        prev_d    = prev_q;
        trend_d   = trend_q;
        stall_hit = 1'b0;
        rotate    = 1'b0;

        // A tripped lead hands over immediately, independent of the tick.
        lead_t = healthy[lead_q] ? lead_q : next_healthy(lead_q, healthy, N_PUMPS);

        if (tick) begin
            prev_d = water_lvl;
            if (rising) begin
                trend_d = 1'b1;
            end else if (falling) begin
                trend_d = 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    off_dw_d = off_inc;
                    stall_d  = '0;
                    if (lvl_low) begin
                        state_d = ST_FILL_ALL;
                        on_dw_d = '0;
                    end else if (!lvl_mid && (off_inc >= DW_W'(MIN_OFF_TICKS))) begin
                        state_d = ST_FILL_LEAD;
                        on_dw_d = '0;
                    end
                end
                ST_FILL_LEAD, ST_FILL_ALL: begin
                    on_dw_d = on_inc;
                    stall_d = rising ? '0 : stall_q + ST_W'(1);
                    if (stall_d == ST_W'(STALL_TICKS)) begin
                        stall_hit = 1'b1;
                        stall_d   = '0;
                    end
                    if (state_q == ST_FILL_LEAD) begin
                        if (lvl_low) begin
                            state_d = ST_FILL_ALL;
                        end else if (lvl_high && (on_inc >= DW_W'(MIN_ON_TICKS))) begin
                            rotate = 1'b1;
                        end
                    end else begin
                        if (lvl_high) begin
                            rotate = 1'b1;
                        end else if (lvl_mid) begin
                            state_d = ST_FILL_LEAD;
                        end
                    end
                    if (rotate) begin
                        state_d  = ST_IDLE;
                        off_dw_d = '0;
                        stall_d  = '0;
                    end
                end
                default: stall_d = '0;
            endcase
        end

        // A clear arriving with a stall detection discards the new lock.
        if (stall_hit && !fault_clr) begin
            lock_d[lead_t] = 1'b1;
        end
        if (fault_clr) begin
            lock_d = '0;
        end
        healthy_n = ~fault8 & ~lock_d & VALID_MASK;

        // Stall and end-of-fill rotation each advance the lead by one healthy slot.
        lead_d = (stall_hit || rotate) ? next_healthy(lead_t, healthy_n, N_PUMPS) : lead_t;

        if (state_q == ST_LOCKOUT) begin
            if (fault_clr && (healthy_n != '0)) begin
                state_d  = ST_IDLE;
                off_dw_d = '0;
            end
        end else if (healthy_n == '0) begin
            state_d = ST_LOCKOUT;
            stall_d = '0;
        end
        if (!healthy_n[lead_d]) begin
            lead_d = next_healthy(lead_d, healthy_n, N_PUMPS);
        end

        case (state_d)
            ST_FILL_LEAD: pump8 = (8'd1 << lead_d) & healthy_n;
            ST_FILL_ALL:  pump8 = healthy_n;
            default:      pump8 = '0;
        endcase
        pump_d  = pump8[N_PUMPS-1:0];
        alarm_d = (|fault8) || (|lock_d) || (state_d == ST_LOCKOUT);
    end

    // Thermometer bar: segments 0..(level >> shift) lit, all dark at zero level.
    always_comb begin
        q_lvl = water_lvl >> SEG_SHIFT;
        ind_d = '0;
        for (int i = 0; i < IND_SEGS; i++) begin
            ind_d[i] = (water_lvl != '0) && (q_lvl >= LVL_W'(i));
        end
    end

    // Control state registers.
    always_ff @(posedge CLK100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            lead_q   <= '0;
            lock_q   <= '0;
            on_dw_q  <= '0;
            off_dw_q <= DW_W'(DWELL_MAX);
            stall_q  <= '0;
            prev_q   <= '0;
            trend_q  <= 1'b0;
            pump_q   <= '0;
            alarm_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            lead_q   <= lead_d;
            lock_q   <= lock_d;
            on_dw_q  <= on_dw_d;
            off_dw_q <= off_dw_d;
            stall_q  <= stall_d;
            prev_q   <= prev_d;
            trend_q  <= trend_d;
            pump_q   <= pump_d;
            alarm_q  <= alarm_d;
        end
    end

    // Level flags and bar, registered every clock.
    always_ff @(posedge CLK100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            low_q  <= 1'b0;
            mid_q  <= 1'b0;
            high_q <= 1'b0;
            ind_q  <= '0;
        end else begin
            low_q  <= lvl_low;
            mid_q  <= lvl_mid;
            high_q <= lvl_high;
            ind_q  <= ind_d;
        end
    end

    assign pump_on          = pump_q;
    assign Low              = low_q;
    assign Mid              = mid_q;
    assign High             = high_q;
    assign water_indication = ind_q;
    assign water_trend      = trend_q;
    assign alarm            = alarm_q;
    assign state            = state_q;

endmodule

// File: tb/tb_multi_pump_plc.sv
// Directed bench for multi_pump_plc with a 4-clock control tick.
// Latency: checks sampled 1 time unit after the clock edge.
// Backpressure: not applicable.
module tb_multi_pump_plc;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] water_lvl = '0;
    logic [1:0] pump_fault = '0;
    logic       fault_clr = 1'b0;
    logic [1:0] pump_on;
    logic       Low, Mid, High;
    logic [7:0] water_indication;
    logic       water_trend, alarm;
    logic [1:0] state;

    int n_tests = 0;
    int n_fail  = 0;

    multi_pump_plc #(.TICK_DIV(4)) dut (
        .CLK100MHZ        (clk),
        .rst_n            (rst_n),
        .water_lvl        (water_lvl),
        .pump_fault       (pump_fault),
        .fault_clr        (fault_clr),
        .pump_on          (pump_on),
        .Low              (Low),
        .Mid              (Mid),
        .High             (High),
        .water_indication (water_indication),
        .water_trend      (water_trend),
        .alarm            (alarm),
        .state            (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One control tick is four clocks; callers stay aligned to tick edges.
    task automatic ticks(input int n);
        step(4 * n);
    endtask

    // Hold reset two clocks, release 1 unit after an edge.
    task automatic do_reset(input logic [7:0] lvl);
        @(posedge clk);
        #1;
        rst_n      = 1'b0;
        water_lvl  = lvl;
        pump_fault = '0;
        fault_clr  = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [7:0] lvl;
        logic [7:0] ind;
        logic       low;
        logic       mid;
        logic       high;
    } lvl_vec_t;

    lvl_vec_t lvl_tab[10] = '{
        '{8'd0,   8'h00, 1'b1, 1'b0, 1'b0},
        '{8'd1,   8'h01, 1'b1, 1'b0, 1'b0},
        '{8'd63,  8'h03, 1'b1, 1'b0, 1'b0},
        '{8'd64,  8'h07, 1'b0, 1'b0, 1'b0},
        '{8'd127, 8'h0F, 1'b0, 1'b0, 1'b0},
        '{8'd128, 8'h1F, 1'b0, 1'b1, 1'b0},
        '{8'd130, 8'h1F, 1'b0, 1'b1, 1'b0},
        '{8'd223, 8'h7F, 1'b0, 1'b1, 1'b0},
        '{8'd224, 8'hFF, 1'b0, 1'b1, 1'b1},
        '{8'd255, 8'hFF, 1'b0, 1'b1, 1'b1}
    };

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Reset state and start-up fill.
        do_reset(8'd50);
        chk("rst_pump",  32'(pump_on), 32'h0);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_low",   32'(Low), 32'd0);
        chk("rst_alarm", 32'(alarm), 32'd0);
        chk("rst_ind",   32'(water_indication), 32'h00);
        step(1);
        chk("start_low", 32'(Low), 32'd1);
        chk("start_ind", 32'(water_indication), 32'h03);
        step(2);
        chk("pre_tick_state", 32'(state), 32'd0);
        step(1);
        chk("start_state", 32'(state), 32'd2);
        chk("start_pump",  32'(pump_on), 32'h3);
        chk("start_trend", 32'(water_trend), 32'd1);

        // Hysteresis and lead rotation.
        water_lvl = 8'd140;
        ticks(1);
        chk("mid_state", 32'(state), 32'd1);
        chk("mid_pump",  32'(pump_on), 32'h1);
        chk("mid_flag",  32'(Mid), 32'd1);
        water_lvl = 8'd230;
        ticks(2);
        chk("dwell_hold_state", 32'(state), 32'd1);
        ticks(1);
        chk("full_state", 32'(state), 32'd0);
        chk("full_pump",  32'(pump_on), 32'h0);
        chk("full_high",  32'(High), 32'd1);
        water_lvl = 8'd100;
        ticks(1);
        chk("fall_trend", 32'(water_trend), 32'd0);
        ticks(2);
        chk("offdwell_state", 32'(state), 32'd0);
        ticks(1);
        chk("rot_state", 32'(state), 32'd1);
        chk("rot_pump",  32'(pump_on), 32'h2);

        // Stall on the lead, then on the remaining pump.
        ticks(15);
        chk("prestall_pump",  32'(pump_on), 32'h2);
        chk("prestall_alarm", 32'(alarm), 32'd0);
        ticks(1);
        chk("stall_pump",  32'(pump_on), 32'h1);
        chk("stall_alarm", 32'(alarm), 32'd1);
        chk("stall_state", 32'(state), 32'd1);
        ticks(15);
        chk("prestall2_pump", 32'(pump_on), 32'h1);
        ticks(1);
        chk("lock_state", 32'(state), 32'd3);
        chk("lock_pump",  32'(pump_on), 32'h0);
        chk("lock_alarm", 32'(alarm), 32'd1);
        fault_clr = 1'b1;
        step(1);
        fault_clr = 1'b0;
        chk("clr_state", 32'(state), 32'd0);
        chk("clr_alarm", 32'(alarm), 32'd0);
        chk("clr_pump",  32'(pump_on), 32'h0);

        // Trip handling, off-tick.
        do_reset(8'd50);
        step(4);
        chk("trip_pre_pump", 32'(pump_on), 32'h3);
        pump_fault = 2'b01;
        step(1);
        chk("trip_pump",  32'(pump_on), 32'h2);
        chk("trip_alarm", 32'(alarm), 32'd1);
        chk("trip_state", 32'(state), 32'd2);
        water_lvl = 8'd140;
        step(3);
        chk("trip_lead_state", 32'(state), 32'd1);
        chk("trip_lead_pump",  32'(pump_on), 32'h2);
        pump_fault = 2'b00;
        step(1);
        chk("untrip_pump",  32'(pump_on), 32'h2);
        chk("untrip_alarm", 32'(alarm), 32'd0);
        pump_fault = 2'b11;
        step(1);
        chk("alltrip_state", 32'(state), 32'd3);
        chk("alltrip_pump",  32'(pump_on), 32'h0);
        pump_fault = 2'b00;
        step(1);
        chk("lock_hold_state", 32'(state), 32'd3);
        fault_clr = 1'b1;
        step(1);
        fault_clr = 1'b0;
        chk("lock_exit_state", 32'(state), 32'd0);
        chk("lock_exit_alarm", 32'(alarm), 32'd0);

        // Thermometer and threshold edges.
        do_reset(8'd0);
        foreach (lvl_tab[i]) begin
            water_lvl = lvl_tab[i].lvl;
            step(1);
            chk($sformatf("ind_%0d", lvl_tab[i].lvl),  32'(water_indication), 32'(lvl_tab[i].ind));
            chk($sformatf("low_%0d", lvl_tab[i].lvl),  32'(Low),  32'(lvl_tab[i].low));
            chk($sformatf("mid_%0d", lvl_tab[i].lvl),  32'(Mid),  32'(lvl_tab[i].mid));
            chk($sformatf("high_%0d", lvl_tab[i].lvl), 32'(High), 32'(lvl_tab[i].high));
        end

        // Trend: rise, fall, equal hold at both polarities.
        do_reset(8'd10);
        step(4);
        chk("trend_rise1", 32'(water_trend), 32'd1);
        water_lvl = 8'd5;
        ticks(1);
        chk("trend_fall", 32'(water_trend), 32'd0);
        ticks(1);
        chk("trend_hold0", 32'(water_trend), 32'd0);
        water_lvl = 8'd9;
        ticks(1);
        chk("trend_rise2", 32'(water_trend), 32'd1);
        ticks(1);
        chk("trend_hold1", 32'(water_trend), 32'd1);
        chk("trend_pump", 32'(pump_on), 32'h3);

        // Asynchronous reset mid-fill drops pumps without a clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_pump",  32'(pump_on), 32'h0);
        chk("async_rst_state", 32'(state), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_pump_plc.md
# multi_pump_plc

Parametrised N-pump tank-fill controller: the next generation of the two-pump PLC. It samples a water-level word and drives N fill pumps with low/mid/high hysteresis, lead-pump rotation, minimum on/off dwell and stall detection with per-pump lockout. It also produces the level flags, the thermometer bar and the trend bit. It sits between the board clock and the water-level source (simulator or ADC front end), replacing the fixed two-pump controller and its external prescaler.

## Interface
- N_PUMPS, 2: pump count, 1..8
- LVL_W, 8: level word width
- IND_SEGS, 8: thermometer segments, power of two, at most 2^LVL_W
- LOW_TH / MID_TH / HIGH_TH, 64 / 128 / 224: thresholds, with LOW_TH < MID_TH < HIGH_TH
- TICK_DIV, 100_000_000: clocks per control tick
- MIN_ON_TICKS / MIN_OFF_TICKS, 4 / 4: dwell limits in ticks
- STALL_TICKS, 16: ticks without a level rise before the lead pump is declared stalled
- CLK100MHZ  in  1  single system clock
- rst_n  in  1  asynchronous, active-low reset
- water_lvl  in  LVL_W  current level, unsigned; higher means fuller
- pump_fault  in  N_PUMPS  external trip per pump, level-sensitive
- fault_clr  in  1  one-cycle pulse; clears stall lockouts and leaves LOCKOUT
- pump_on  out  N_PUMPS  pump drive
- Low / Mid / High  out  1  water_lvl < LOW_TH / ≥ MID_TH / ≥ HIGH_TH
- water_indication  out  IND_SEGS  thermometer bar
- water_trend  out  1  1 = level rising at last tick, 0 = falling
- alarm  out  1  any pump tripped or locked out
- state  out  2  IDLE=0, FILL_LEAD=1, FILL_ALL=2, LOCKOUT=3

## Operation
- **Healthy pump:** a pump is healthy when its pump_fault bit is 0 and its stall-lock bit is 0.
- **Lead pump:** the lead pointer always references a healthy pump.
- **Tick:** a strobe pulses for one clock every TICK_DIV clocks. The FSM, dwell counters, stall counter and trend update only on tick.
- **IDLE:**
  - Level < LOW_TH → FILL_ALL.
  - Otherwise, level < MID_TH and off-dwell ≥ MIN_OFF_TICKS → FILL_LEAD.
- **FILL_LEAD:**
  - The lead pump is on.
  - Level < LOW_TH → FILL_ALL.
  - Level ≥ HIGH_TH and on-dwell ≥ MIN_ON_TICKS → IDLE, and the lead advances to the next healthy index (modulo N_PUMPS).
- **FILL_ALL:**
  - All healthy pumps are on.
  - Level ≥ HIGH_TH → IDLE, with the lead rotated as above.
  - Otherwise, level ≥ MID_TH → FILL_LEAD.
- **Dwell:** the dwell counters saturate. On-dwell counts from FILL_* entry; off-dwell counts from IDLE entry.
- **Stall:**
  - In FILL_*, the stall counter resets on any tick where the level exceeds the previous tick's sample.
  - When it reaches STALL_TICKS, the lead's stall-lock bit is set, alarm is asserted, the lead advances and the counter clears.
- **Trip:** pump_fault forces that pump's output off on the next clock, regardless of tick. If the tripped pump is the lead, the lead advances on that same clock.
- **LOCKOUT:**
  - Entered on the next clock when no pump is healthy.
  - All pumps are off and alarm = 1.
  - fault_clr clears all stall-lock bits. The FSM then returns to IDLE on the next clock if any pump is healthy; otherwise it stays in LOCKOUT.
- **Thermometer:** let q = water_lvl >> (LVL_W − log2 IND_SEGS). Segments 0..q are lit; all segments are dark when water_lvl = 0.
- **Trend:** each tick compares the sample with the previous tick's sample. Greater → 1, smaller → 0, equal → hold.
- **Sampling:** water_lvl is treated as synchronous to CLK100MHZ.

## Timing
- **Reset values:** all outputs 0, state IDLE, lead 0, stall locks clear, all counters 0, off-dwell saturated.
- **Reset mid-operation:** all pumps drop within the same cycle (asynchronous clear).
- **Combinational level outputs:** Low/Mid/High and water_indication are registered, with 1-cycle latency from water_lvl.
- **Pump response:** pump_on and state change on the clock edge following the tick on which the decision is made.
- **Simultaneous events:**
  - A trip has priority over a tick decision in the same cycle.
  - fault_clr coinciding with a stall detection: the clear wins and the new lock is discarded.
- **Threshold equality:**
  - level = HIGH_TH counts as full.
  - level = LOW_TH is not Low.

## Structure
- **Shared package pump_plc_pkg:** the state enum, the state encodings and a function returning the next healthy index with wrap-around.
- **Sub-module pump_tick_gen:** the tick divider. Its counter is sized to log2 TICK_DIV and it has the same clock/reset.
- **Top level:** FSM, dwell/stall counters, lead pointer and output registers.

## Test plan
- **Start-up fill:** TICK_DIV=4, reset, water_lvl=50 → after the first tick, state=FILL_ALL and pump_on=2'b11; Low=1 one cycle after reset release.
- **Hysteresis and rotation:**
  - Ramp the level 50→140 → FILL_LEAD with pump_on=2'b01.
  - Ramp to 230 after 4 ticks → IDLE, and the next fill uses pump_on=2'b10.
- **Stall:** FILL_LEAD with water_lvl held at 100 for 16 ticks → lead locked, alarm=1, pump_on moves to the other pump.
- **Lockout:**
  - Stall both pumps → state=3 and pump_on=0.
  - Pulse fault_clr → state=IDLE on the next clock, alarm=0.
- **Trip:** assert pump_fault[0] mid-fill → pump_on[0]=0 on the next clock, without waiting for a tick.
- **Thermometer and trend:**
  - water_lvl=0/1/130/255 → water_indication=8'h00/8'h01/8'h1F/8'hFF.
  - Rising samples give trend=1; an equal sample holds the trend.
